// File: rtl/mem_access_if.sv
// mem_access_if: single-beat AXI4 data master bus between the load/store unit and the interconnect
interface mem_access_if #(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_AWUSER_WIDTH    = 1,
    parameter int C_M_AXI_WUSER_WIDTH     = 4,
    parameter int C_M_AXI_RUSER_WIDTH     = 4,
    parameter int C_M_AXI_BUSER_WIDTH     = 1
);
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_AWID;
    logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR;
    logic [7:0]                          M_AXI_AWLEN;
    logic [2:0]                          M_AXI_AWSIZE;
    logic [1:0]                          M_AXI_AWBURST;
    logic                                M_AXI_AWLOCK;
    logic [3:0]                          M_AXI_AWCACHE;
    logic [2:0]                          M_AXI_AWPROT;
    logic [3:0]                          M_AXI_AWQOS;
    logic [C_M_AXI_AWUSER_WIDTH-1:0]     M_AXI_AWUSER;
    logic                                M_AXI_AWVALID;
    logic                                M_AXI_AWREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB;
    logic                                M_AXI_WLAST;
    logic [C_M_AXI_WUSER_WIDTH-1:0]      M_AXI_WUSER;
    logic                                M_AXI_WVALID;
    logic                                M_AXI_WREADY;
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_BID;
    logic [1:0]                          M_AXI_BRESP;
    logic [C_M_AXI_BUSER_WIDTH-1:0]      M_AXI_BUSER;
    logic                                M_AXI_BVALID;
    logic                                M_AXI_BREADY;
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_ARID;
    logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_ARADDR;
    logic [7:0]                          M_AXI_ARLEN;
    logic [2:0]                          M_AXI_ARSIZE;
    logic [1:0]                          M_AXI_ARBURST;
    logic                                M_AXI_ARLOCK;
    logic [3:0]                          M_AXI_ARCACHE;
    logic [2:0]                          M_AXI_ARPROT;
    logic [3:0]                          M_AXI_ARQOS;
    logic [C_M_AXI_ARUSER_WIDTH-1:0]     M_AXI_ARUSER;
    logic                                M_AXI_ARVALID;
    logic                                M_AXI_ARREADY;
    logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_AXI_RID;
    logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_RDATA;
    logic [1:0]                          M_AXI_RRESP;
    logic                                M_AXI_RLAST;
    logic [C_M_AXI_RUSER_WIDTH-1:0]      M_AXI_RUSER;
    logic                                M_AXI_RVALID;
    logic                                M_AXI_RREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
               M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
               M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
               M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_ARVALID,
               M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
               M_AXI_ARREADY,
               M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
               M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID,
               M_AXI_BREADY,
               M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
               M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_ARVALID,
               M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY,
               M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID,
               M_AXI_ARREADY,
               M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I load/store unit issuing single-beat AXI4 reads and writes
module mem_access #(
    parameter int C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ_VALID,
    input  logic                          REQ_WE,
    input  logic [2:0]                    REQ_FUNCT3,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [31:0]                   REQ_WDATA,
    output logic                          MEM_WAIT,
    output logic                          RESP_VALID,
    output logic [31:0]                   RESP_RDATA,
    output logic                          RESP_ERR,
    mem_access_if.master                  M_AXI
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE} state_t;

    state_t                          state, state_nx;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]                      f3_q;
    logic [3:0]                      strb_q, strb_d;
    logic [31:0]                     wdata_q, wdata_d, rdata_q, rshift, rext;
    logic                            err_q, aw_done, w_done, reject;

    assign M_AXI.M_AXI_AWID    = '0;
    assign M_AXI.M_AXI_AWADDR  = {addr_q[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign M_AXI.M_AXI_AWLEN   = 8'd0;
    assign M_AXI.M_AXI_AWSIZE  = 3'b010;
    assign M_AXI.M_AXI_AWBURST = 2'b01;
    assign M_AXI.M_AXI_AWLOCK  = 1'b0;
    assign M_AXI.M_AXI_AWCACHE = 4'b0011;
    assign M_AXI.M_AXI_AWPROT  = 3'b000;
    assign M_AXI.M_AXI_AWQOS   = 4'b0000;
    assign M_AXI.M_AXI_AWUSER  = '0;
    assign M_AXI.M_AXI_AWVALID = state == WR_ADDR_DATA && !aw_done;
    assign M_AXI.M_AXI_WDATA   = wdata_q;
    assign M_AXI.M_AXI_WSTRB   = strb_q;
    assign M_AXI.M_AXI_WLAST   = M_AXI.M_AXI_WVALID;
    assign M_AXI.M_AXI_WUSER   = '0;
    assign M_AXI.M_AXI_WVALID  = state == WR_ADDR_DATA && !w_done;
    assign M_AXI.M_AXI_BREADY  = state == WR_RESP;
    assign M_AXI.M_AXI_ARID    = '0;
    assign M_AXI.M_AXI_ARADDR  = {addr_q[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign M_AXI.M_AXI_ARLEN   = 8'd0;
    assign M_AXI.M_AXI_ARSIZE  = 3'b010;
    assign M_AXI.M_AXI_ARBURST = 2'b01;
    assign M_AXI.M_AXI_ARLOCK  = 1'b0;
    assign M_AXI.M_AXI_ARCACHE = 4'b0011;
    assign M_AXI.M_AXI_ARPROT  = 3'b000;
    assign M_AXI.M_AXI_ARQOS   = 4'b0000;
    assign M_AXI.M_AXI_ARUSER  = '0;
    assign M_AXI.M_AXI_ARVALID = state == RD_ADDR;
    assign M_AXI.M_AXI_RREADY  = state == RD_DATA;

    assign MEM_WAIT   = (state != IDLE && state != DONE) || (state == IDLE && REQ_VALID);
    assign RESP_VALID = state == DONE;
    assign RESP_RDATA = rdata_q;
    assign RESP_ERR   = err_q;

    // Decode the incoming request: reject bad funct3/misalignment, build lane strobes and replicated store data
    always_comb begin
        reject  = (REQ_WE ? REQ_FUNCT3 > 3'b010 : (REQ_FUNCT3[1:0] == 2'b11 || REQ_FUNCT3 == 3'b110))
                || (REQ_FUNCT3[1:0] == 2'b01 && REQ_ADDR[0])
                || (REQ_FUNCT3[1:0] == 2'b10 && REQ_ADDR[1:0] != 2'b00);
        strb_d  = REQ_FUNCT3[1:0] == 2'b00 ? 4'b0001 << REQ_ADDR[1:0] :
                  REQ_FUNCT3[1:0] == 2'b01 ? 4'b0011 << REQ_ADDR[1:0] : 4'b1111;
        wdata_d = REQ_FUNCT3[1:0] == 2'b00 ? {4{REQ_WDATA[7:0]}} :
                  REQ_FUNCT3[1:0] == 2'b01 ? {2{REQ_WDATA[15:0]}} : REQ_WDATA;
    end

    // Align the addressed bytes of the read beat to bit 0 and extend per funct3
    always_comb begin
        rshift = M_AXI.M_AXI_RDATA >> {addr_q[1:0], 3'b000};
        rext   = f3_q == 3'b000 ? {{24{rshift[7]}}, rshift[7:0]} :
                 f3_q == 3'b100 ? {24'd0, rshift[7:0]} :
                 f3_q == 3'b001 ? {{16{rshift[15]}}, rshift[15:0]} :
                 f3_q == 3'b101 ? {16'd0, rshift[15:0]} : rshift;
    end

    // State register
    always_ff @(posedge CLK) begin
        state <= RST ? IDLE : state_nx;
    end

    // Next-state logic; a write leaves WR_ADDR_DATA only once both AW and W have handshaken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (REQ_VALID) state_nx = reject ? DONE : REQ_WE ? WR_ADDR_DATA : RD_ADDR;
            RD_ADDR:      if (M_AXI.M_AXI_ARREADY) state_nx = RD_DATA;
            RD_DATA:      if (M_AXI.M_AXI_RVALID) state_nx = DONE;
            WR_ADDR_DATA: if ((aw_done || M_AXI.M_AXI_AWREADY) && (w_done || M_AXI.M_AXI_WREADY)) state_nx = WR_RESP;
            WR_RESP:      if (M_AXI.M_AXI_BVALID) state_nx = DONE;
            default:      state_nx = IDLE;
        endcase
    end

    // Request latch, per-channel write handshake tracking and response capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            f3_q    <= 3'd0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (REQ_VALID) begin
                    addr_q  <= REQ_ADDR;
                    f3_q    <= REQ_FUNCT3;
                    strb_q  <= strb_d;
                    wdata_q <= wdata_d;
                    rdata_q <= 32'd0;
                    err_q   <= reject;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                RD_DATA: if (M_AXI.M_AXI_RVALID) begin
                    err_q   <= M_AXI.M_AXI_RRESP != 2'b00;
                    rdata_q <= M_AXI.M_AXI_RRESP != 2'b00 ? 32'd0 : rext;
                end
                WR_ADDR_DATA: begin
                    aw_done <= aw_done || M_AXI.M_AXI_AWREADY;
                    w_done  <= w_done || M_AXI.M_AXI_WREADY;
                end
                WR_RESP: if (M_AXI.M_AXI_BVALID) err_q <= M_AXI.M_AXI_BRESP != 2'b00;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven load/store vectors against a cycle-scripted AXI slave with a response scoreboard
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_f3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        mem_wait, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int          nvec = 0, nerr = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, sdata;
        logic [1:0]  resp;
        logic        bad;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_rdata;
        logic        exp_err;
        int          ar_dly, aw_dly, w_dly;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  tbl[16];

    mem_access_if bus ();

    mem_access dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_WE(req_we), .REQ_FUNCT3(req_f3),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .MEM_WAIT(mem_wait), .RESP_VALID(resp_valid), .RESP_RDATA(resp_rdata), .RESP_ERR(resp_err),
        .M_AXI(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        resp_t e;
        @(negedge clk);
        if (resp_valid) begin
            if (sb.size() == 0) chk("unexpected_resp_valid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    endtask

    task automatic run(input vec_t v);
        bit aw_ok, w_ok;
        int nmax;
        req_valid = 1'b1; req_we = v.we; req_f3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        sb.push_back('{v.bad ? 32'd0 : v.exp_rdata, v.bad ? 1'b1 : v.exp_err});
        #1 chk("mem_wait_accept", {31'd0, mem_wait}, 32'd1);
        step();
        req_valid = 1'b0;
        if (v.bad) begin
            chk("bad_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
            chk("bad_awvalid", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
            chk("bad_wvalid", {31'd0, bus.M_AXI_WVALID}, 32'd0);
        end else if (!v.we) begin
            for (int n = 0; n <= v.ar_dly; n++) begin
                chk("arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd1);
                chk("araddr", bus.M_AXI_ARADDR, v.exp_addr);
                chk("mem_wait_rd_addr", {31'd0, mem_wait}, 32'd1);
                chk("rready_early", {31'd0, bus.M_AXI_RREADY}, 32'd0);
                chk("resp_valid_early", {31'd0, resp_valid}, 32'd0);
                bus.M_AXI_ARREADY = (n == v.ar_dly);
                step();
            end
            bus.M_AXI_ARREADY = 1'b0;
            chk("arvalid_after_hs", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
            chk("rready", {31'd0, bus.M_AXI_RREADY}, 32'd1);
            chk("mem_wait_rd_data", {31'd0, mem_wait}, 32'd1);
            bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = v.sdata; bus.M_AXI_RRESP = v.resp;
            step();
            bus.M_AXI_RVALID = 1'b0;
        end else begin
            aw_ok = 1'b0; w_ok = 1'b0;
            nmax = v.aw_dly > v.w_dly ? v.aw_dly : v.w_dly;
            for (int n = 0; n <= nmax; n++) begin
                chk("awvalid", {31'd0, bus.M_AXI_AWVALID}, {31'd0, !aw_ok});
                chk("wvalid", {31'd0, bus.M_AXI_WVALID}, {31'd0, !w_ok});
                chk("wlast", {31'd0, bus.M_AXI_WLAST}, {31'd0, !w_ok});
                chk("mem_wait_wr", {31'd0, mem_wait}, 32'd1);
                chk("resp_valid_early", {31'd0, resp_valid}, 32'd0);
                if (!aw_ok) chk("awaddr", bus.M_AXI_AWADDR, v.exp_addr);
                if (!w_ok) begin
                    chk("wstrb", {28'd0, bus.M_AXI_WSTRB}, {28'd0, v.exp_strb});
                    chk("wdata", bus.M_AXI_WDATA, v.exp_wdata);
                end
                bus.M_AXI_AWREADY = (n == v.aw_dly);
                bus.M_AXI_WREADY = (n == v.w_dly);
                step();
                aw_ok |= (n == v.aw_dly);
                w_ok |= (n == v.w_dly);
            end
            bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
            chk("awvalid_after_hs", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
            chk("wvalid_after_hs", {31'd0, bus.M_AXI_WVALID}, 32'd0);
            chk("bready", {31'd0, bus.M_AXI_BREADY}, 32'd1);
            bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = v.resp;
            step();
            bus.M_AXI_BVALID = 1'b0;
        end
        chk("resp_valid_done", {31'd0, resp_valid}, 32'd1);
        chk("mem_wait_done", {31'd0, mem_wait}, 32'd0);
        chk("rready_done", {31'd0, bus.M_AXI_RREADY}, 32'd0);
        chk("bready_done", {31'd0, bus.M_AXI_BREADY}, 32'd0);
        step();
        chk("resp_valid_pulse", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        vec_t lw;
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00; bus.M_AXI_BID = '0; bus.M_AXI_BUSER = '0;
        bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = 32'd0;
        bus.M_AXI_RID = '0; bus.M_AXI_RLAST = 1'b1; bus.M_AXI_RUSER = '0;

        tbl[0]  = '{0, 3'b000, 32'h1003, 32'h0,         32'h80FF_0000, 2'b00, 0, 32'h1000, 4'h0, 32'h0,         32'hFFFF_FF80, 0, 0, 0, 0};
        tbl[1]  = '{0, 3'b101, 32'h2002, 32'h0,         32'h8001_1234, 2'b00, 0, 32'h2000, 4'h0, 32'h0,         32'h0000_8001, 0, 0, 0, 0};
        tbl[2]  = '{0, 3'b010, 32'h2000, 32'h0,         32'hDEAD_BEEF, 2'b00, 0, 32'h2000, 4'h0, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0};
        tbl[3]  = '{0, 3'b001, 32'h2002, 32'h0,         32'h8001_1234, 2'b00, 0, 32'h2000, 4'h0, 32'h0,         32'hFFFF_8001, 0, 2, 0, 0};
        tbl[4]  = '{0, 3'b100, 32'h1001, 32'h0,         32'h0000_AB00, 2'b00, 0, 32'h1000, 4'h0, 32'h0,         32'h0000_00AB, 0, 1, 0, 0};
        tbl[5]  = '{1, 3'b000, 32'h3001, 32'h1234_56AB, 32'h0,         2'b00, 0, 32'h3000, 4'h2, 32'hABAB_ABAB, 32'h0,         0, 0, 0, 0};
        tbl[6]  = '{1, 3'b000, 32'h3001, 32'h1234_56AB, 32'h0,         2'b00, 0, 32'h3000, 4'h2, 32'hABAB_ABAB, 32'h0,         0, 0, 3, 0};
        tbl[7]  = '{1, 3'b001, 32'h3002, 32'hCAFE_BEEF, 32'h0,         2'b00, 0, 32'h3000, 4'hC, 32'hBEEF_BEEF, 32'h0,         0, 0, 0, 2};
        tbl[8]  = '{1, 3'b010, 32'h3004, 32'h1122_3344, 32'h0,         2'b00, 0, 32'h3004, 4'hF, 32'h1122_3344, 32'h0,         0, 0, 1, 1};
        tbl[9]  = '{1, 3'b010, 32'h4002, 32'h5555_5555, 32'h0,         2'b00, 1, 32'h0,    4'h0, 32'h0,         32'h0,         1, 0, 0, 0};
        tbl[10] = '{0, 3'b001, 32'h5001, 32'h0,         32'h0,         2'b00, 1, 32'h0,    4'h0, 32'h0,         32'h0,         1, 0, 0, 0};
        tbl[11] = '{0, 3'b010, 32'h6000, 32'h0,         32'h55AA_55AA, 2'b10, 0, 32'h6000, 4'h0, 32'h0,         32'h0,         1, 5, 0, 0};
        tbl[12] = '{0, 3'b011, 32'h0000, 32'h0,         32'h0,         2'b00, 1, 32'h0,    4'h0, 32'h0,         32'h0,         1, 0, 0, 0};
        tbl[13] = '{1, 3'b100, 32'h0000, 32'h0,         32'h0,         2'b00, 1, 32'h0,    4'h0, 32'h0,         32'h0,         1, 0, 0, 0};
        tbl[14] = '{1, 3'b010, 32'h7000, 32'hA5A5_0F0F, 32'h0,         2'b11, 0, 32'h7000, 4'hF, 32'hA5A5_0F0F, 32'h0,         1, 0, 0, 0};
        tbl[15] = '{0, 3'b000, 32'h1002, 32'h0,         32'h007F_0000, 2'b00, 0, 32'h1000, 4'h0, 32'h0,         32'h0000_007F, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
        chk("rst_awvalid", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
        chk("rst_wvalid", {31'd0, bus.M_AXI_WVALID}, 32'd0);
        chk("rst_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);
        chk("rst_bready", {31'd0, bus.M_AXI_BREADY}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("rst_awaddr", bus.M_AXI_AWADDR, 32'd0);
        chk("rst_wstrb", {28'd0, bus.M_AXI_WSTRB}, 32'd0);
        chk("rst_wdata", bus.M_AXI_WDATA, 32'd0);

        for (int i = 0; i < 16; i++) run(tbl[i]);

        chk("arsize", {29'd0, bus.M_AXI_ARSIZE}, 32'd2);
        chk("arburst", {30'd0, bus.M_AXI_ARBURST}, 32'd1);
        chk("awcache", {28'd0, bus.M_AXI_AWCACHE}, 32'd3);
        chk("awlen", {24'd0, bus.M_AXI_AWLEN}, 32'd0);

        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h8000;
        step();
        req_valid = 1'b0;
        bus.M_AXI_ARREADY = 1'b1;
        step();
        bus.M_AXI_ARREADY = 1'b0;
        chk("rst_seq_rready_before", {31'd0, bus.M_AXI_RREADY}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_seq_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);
        chk("rst_seq_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
        chk("rst_seq_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_seq_mem_wait", {31'd0, mem_wait}, 32'd0);
        bus.M_AXI_RVALID = 1'b1;
        step();
        bus.M_AXI_RVALID = 1'b0;
        chk("rst_seq_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_seq_idle_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);

        lw = '{0, 3'b010, 32'h8004, 32'h0, 32'h0BAD_F00D, 2'b00, 0, 32'h8004, 4'h0, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 0};
        run(lw);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
